// File: rtl/spgd_sequencer.sv
// spgd_sequencer: SPGD perturb/settle/measure/update sequencer for two DAC actuators; define SPGD_ADC_TWOS_EN for a two's-complement ADC_IN
module spgd_sequencer #(
    parameter int          SETTLE_CYCLES = 64,
    parameter int          AVG_LOG2      = 4,
    parameter logic [13:0] PERT_AMP      = 14'd64,
    parameter int          GAIN_SHIFT    = 6
) (
    input  logic        ADC_CLK,
    input  logic        RST,
    input  logic        TRIG_IN,
    input  logic        ENABLE,
    input  logic [11:0] ADC_IN,
    output logic [13:0] DAC_A_OUT,
    output logic [13:0] DAC_B_OUT,
    output logic        BUSY,
    output logic [15:0] ITER_COUNT,
    output logic        OVERRUN,
    output logic [2:0]  STATE_OUT
);
    localparam int AW = 12 + AVG_LOG2;
    localparam int DW = 13 + AVG_LOG2;
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] MEAS_LAST = 16'((1 << AVG_LOG2) - 1);
    localparam logic signed [31:0] PERT = $signed(32'(PERT_AMP));
    typedef enum logic [2:0] {
        IDLE, APPLY_P, SETTLE_P, MEAS_P, APPLY_M, SETTLE_M, MEAS_M, UPDATE
    } state_t;
    state_t state, next_state;
    logic [2:0] trig_sync;
    logic trig_edge, abort, s_a, s_b;
    logic [15:0] lfsr, cnt;
    logic [13:0] base_a, base_b, plus_a, plus_b, minus_a, minus_b, upd_a, upd_b;
    logic [AW-1:0] j_p, j_m;
    logic [11:0] adc_val;
    logic signed [DW-1:0] d_j;
    logic signed [31:0] d, base_a_s, base_b_s;
    function automatic logic [13:0] sat14(input logic signed [31:0] v);
        return v < 0 ? 14'd0 : (v > 32'sd16383 ? 14'h3FFF : v[13:0]);
    endfunction
`ifdef SPGD_ADC_TWOS_EN
    assign adc_val = {~ADC_IN[11], ADC_IN[10:0]};
`else
    assign adc_val = ADC_IN;
`endif
    assign trig_edge = trig_sync[1] & ~trig_sync[2];
    assign abort = !ENABLE && state != IDLE && state != UPDATE;
    assign d_j = $signed({1'b0, j_p}) - $signed({1'b0, j_m});
    assign d = 32'(d_j >>> GAIN_SHIFT);
    assign base_a_s = $signed({18'd0, base_a});
    assign base_b_s = $signed({18'd0, base_b});
    assign plus_a = sat14(base_a_s + (s_a ? -PERT : PERT));
    assign plus_b = sat14(base_b_s + (s_b ? -PERT : PERT));
    assign minus_a = sat14(base_a_s + (s_a ? PERT : -PERT));
    assign minus_b = sat14(base_b_s + (s_b ? PERT : -PERT));
    assign upd_a = sat14(base_a_s + (s_a ? -d : d));
    assign upd_b = sat14(base_b_s + (s_b ? -d : d));
    assign BUSY = state != IDLE;
    assign STATE_OUT = state;
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     next_state = trig_edge && ENABLE ? APPLY_P : IDLE;
            APPLY_P:  next_state = SETTLE_P;
            SETTLE_P: next_state = cnt == SETTLE_LAST ? MEAS_P : SETTLE_P;
            MEAS_P:   next_state = cnt == MEAS_LAST ? APPLY_M : MEAS_P;
            APPLY_M:  next_state = SETTLE_M;
            SETTLE_M: next_state = cnt == SETTLE_LAST ? MEAS_M : SETTLE_M;
            MEAS_M:   next_state = cnt == MEAS_LAST ? UPDATE : MEAS_M;
            default:  next_state = IDLE;
        endcase
        if (abort)
            next_state = IDLE;
    end
    always_ff @(posedge ADC_CLK) begin
        if (RST) begin
            state <= IDLE;
            trig_sync <= '0;
            lfsr <= 16'hACE1;
            s_a <= 1'b0;
            s_b <= 1'b0;
            cnt <= '0;
            base_a <= 14'h2000;
            base_b <= 14'h2000;
            DAC_A_OUT <= 14'h2000;
            DAC_B_OUT <= 14'h2000;
            j_p <= '0;
            j_m <= '0;
            ITER_COUNT <= '0;
            OVERRUN <= 1'b0;
        end else begin
            state <= next_state;
            trig_sync <= {trig_sync[1:0], TRIG_IN};
            cnt <= next_state == state ? cnt + 16'd1 : '0;
            if (trig_edge && state != IDLE)
                OVERRUN <= 1'b1;
            if (state == IDLE && next_state == APPLY_P) begin
                s_a <= lfsr[0];
                s_b <= lfsr[1];
            end
            j_p <= state == APPLY_P ? '0 : state == MEAS_P ? j_p + AW'(adc_val) : j_p;
            j_m <= state == APPLY_M ? '0 : state == MEAS_M ? j_m + AW'(adc_val) : j_m;
            // abort takes priority so an interrupted perturbation always falls back to base
            DAC_A_OUT <= abort || state == IDLE ? base_a : state == APPLY_P ? plus_a :
                         state == APPLY_M ? minus_a : state == UPDATE ? upd_a : DAC_A_OUT;
            DAC_B_OUT <= abort || state == IDLE ? base_b : state == APPLY_P ? plus_b :
                         state == APPLY_M ? minus_b : state == UPDATE ? upd_b : DAC_B_OUT;
            if (state == UPDATE) begin
                base_a <= upd_a;
                base_b <= upd_b;
                ITER_COUNT <= ITER_COUNT + 16'd1;
                lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            end
        end
    end
endmodule

// File: tb/tb_spgd_sequencer.sv
// tb_spgd_sequencer: randomized bench for spgd_sequencer (default gain and GAIN_SHIFT=0 instances) against an iteration-level model
module tb_spgd_sequencer;
    localparam int S = 64, N = 16, P = 64;
    localparam int BUSY_N = 2 * S + 2 * N + 3;
    localparam int T_MP = 1 + S, T_SM = 2 + S + N, T_MM = 2 + 2 * S + N;
    logic clk = 1'b0, rst, trig, en;
    logic [11:0] adc;
    logic [1:0][13:0] dac_a, dac_b;
    logic [1:0][15:0] iter;
    logic [1:0][2:0] st;
    logic [1:0] busy, ovr;
    int n_chk = 0, n_fail = 0;
    int m_lfsr, m_iter, m_ovr;
    int m_base[2][2];
    always #5 clk = ~clk;
    spgd_sequencer u_dut (
        .ADC_CLK(clk), .RST(rst), .TRIG_IN(trig), .ENABLE(en), .ADC_IN(adc),
        .DAC_A_OUT(dac_a[0]), .DAC_B_OUT(dac_b[0]), .BUSY(busy[0]),
        .ITER_COUNT(iter[0]), .OVERRUN(ovr[0]), .STATE_OUT(st[0])
    );
    spgd_sequencer #(.GAIN_SHIFT(0)) u_sat (
        .ADC_CLK(clk), .RST(rst), .TRIG_IN(trig), .ENABLE(en), .ADC_IN(adc),
        .DAC_A_OUT(dac_a[1]), .DAC_B_OUT(dac_b[1]), .BUSY(busy[1]),
        .ITER_COUNT(iter[1]), .OVERRUN(ovr[1]), .STATE_OUT(st[1])
    );
    function automatic int gain(input int k);
        return k == 0 ? 6 : 0;
    endfunction
    function automatic int clamp14(input int v);
        return v < 0 ? 0 : (v > 16383 ? 16383 : v);
    endfunction
    function automatic int metric(input logic [11:0] v);
`ifdef SPGD_ADC_TWOS_EN
        return int'(v ^ 12'h800);
`else
        return int'(v);
`endif
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_iter = 0;
        m_ovr = 0;
        for (int k = 0; k < 2; k++) begin
            m_base[k][0] = 16'h2000;
            m_base[k][1] = 16'h2000;
        end
    endtask
    task automatic check_idle(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_dac_a%0d", tag, k), 32'(dac_a[k]), 32'(m_base[k][0]));
            check($sformatf("%s_dac_b%0d", tag, k), 32'(dac_b[k]), 32'(m_base[k][1]));
            check($sformatf("%s_busy%0d", tag, k), 32'(busy[k]), 0);
            check($sformatf("%s_iter%0d", tag, k), 32'(iter[k]), 32'(m_iter));
            check($sformatf("%s_state%0d", tag, k), 32'(st[k]), 0);
            check($sformatf("%s_ovr%0d", tag, k), 32'(ovr[k]), 32'(m_ovr));
        end
    endtask
    // mode 0: constant vp in the plus half, vm in the minus half; mode 1: fresh random sample every cycle
    task automatic do_iter(input int mode, input logic [11:0] vp, input logic [11:0] vm,
                           input int abort_at, input int retrig_at);
        int i, w, jp, jm, sa, sb, dj, dd, pa;
        logic [11:0] v;
        sa = m_lfsr & 1;
        sb = (m_lfsr >> 1) & 1;
        trig = 1'b0;
        repeat (4) @(negedge clk);
        trig = 1'b1;
        w = 0;
        while (!busy[0] && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("busy_rise", 32'(busy[0]), 1);
        i = 0; jp = 0; jm = 0;
        while (busy[0] && i < 1000) begin
            v = mode == 1 ? 12'($urandom_range(0, 4095)) : (i < T_SM ? vp : vm);
            adc = v;
            if (i >= T_MP && i < T_MP + N) jp += metric(v);
            if (i >= T_MM && i < T_MM + N) jm += metric(v);
            if (i == 5 || i == retrig_at + 5) trig = 1'b0;
            if (i == retrig_at) begin
                trig = 1'b1;
                m_ovr = 1;
            end
            if (i == T_MP || i == T_MM) begin
                pa = i == T_MP ? P : -P;
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("pert_a%0d_%0d", k, i), 32'(dac_a[k]), 32'(clamp14(m_base[k][0] + (sa ? -pa : pa))));
                    check($sformatf("pert_b%0d_%0d", k, i), 32'(dac_b[k]), 32'(clamp14(m_base[k][1] + (sb ? -pa : pa))));
                end
            end
            if (i == abort_at) en = 1'b0;
            @(negedge clk);
            i++;
        end
        check("busy_len", 32'(i), 32'(abort_at >= 0 ? abort_at + 1 : BUSY_N));
        if (abort_at < 0) begin
            dj = jp - jm;
            for (int k = 0; k < 2; k++) begin
                dd = dj >>> gain(k);
                m_base[k][0] = clamp14(m_base[k][0] + (sa ? -dd : dd));
                m_base[k][1] = clamp14(m_base[k][1] + (sb ? -dd : dd));
            end
            m_lfsr = (m_lfsr >> 1) | ((((m_lfsr) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15);
            m_iter = (m_iter + 1) & 16'hFFFF;
        end
        en = 1'b1;
        check_idle(abort_at >= 0 ? "abort" : "done");
    endtask
    initial begin
        rst = 1'b1; trig = 1'b0; en = 1'b0; adc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        en = 1'b1;
        do_iter(0, 12'h7FF, 12'h7FF, -1, -1);
        do_iter(0, 12'h523, 12'h4FA, -1, -1);
        check("grad_step", 32'(dac_a[0]), 32'(16'h2000 + ((m_lfsr_prev_sa() != 0) ? -10 : 10)));
        repeat (3) do_iter(1, 12'h0, 12'h0, -1, -1);
        do_iter(1, 12'h0, 12'h0, 2 + S + N + 3, -1);
        trig = 1'b0; en = 1'b0;
        repeat (4) @(negedge clk);
        trig = 1'b1;
        repeat (8) @(negedge clk);
        check("en_low_ignored", 32'(busy[0]), 0);
        trig = 1'b0; en = 1'b1;
        do_iter(1, 12'h0, 12'h0, -1, 40);
        repeat (10) @(negedge clk);
        check("ovr_no_restart", 32'(busy[0] | busy[1]), 0);
        repeat (4) do_iter(0, 12'hFFF, 12'h000, -1, -1);
        trig = 1'b1;
        repeat (3) @(negedge clk);
        trig = 1'b0;
        repeat (70) begin
            adc = 12'($urandom_range(0, 4095));
            @(negedge clk);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        check_idle("mid_reset");
        rst = 1'b0;
        do_iter(0, 12'h600, 12'h5F0, -1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
    // sign of channel A in the gradient iteration: the LFSR state after one advance from the seed
    function automatic int m_lfsr_prev_sa();
        int l;
        l = 16'hACE1;
        l = (l >> 1) | ((((l) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1) << 15);
        return l & 1;
    endfunction
endmodule
